// File: rtl/overlay_fader.sv
// Blends the overlay pixel over the background with a frame-stepped alpha fade,
// registering colour and syncs together so the VGA pins see aligned outputs.
module overlay_fader #(
    parameter int FADE_FRAMES = 4,
    parameter bit SYNC_NEG    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [5:0] bg_rgb,
    input  logic       ov_draw,
    input  logic [5:0] ov_rgb,
    input  logic       show_req,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [2:0] alpha,
    output logic       busy
);

    localparam logic          SYNC_IDLE = SYNC_NEG ? 1'b1 : 1'b0;
    localparam int            CW        = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          vs_hist;
    logic          frame_tick;
    logic [5:0]    blend_rgb;

    // Frame start is the vsync inactive->active edge; alpha only moves here.
    assign frame_tick = (vsync != SYNC_IDLE) && (vs_hist == SYNC_IDLE);

    function automatic logic [1:0] mix(input logic [1:0] o, input logic [1:0] b,
                                       input logic [2:0] a);
        logic [4:0] sum;
        sum = 5'(o) * 5'(a) + 5'(b) * (5'd4 - 5'(a));
        return 2'(sum >> 2);
    endfunction

    always_comb begin
        blend_rgb = 6'd0;
        if (active) begin
            if (ov_draw)
                blend_rgb = {mix(ov_rgb[5:4], bg_rgb[5:4], alpha),
                             mix(ov_rgb[3:2], bg_rgb[3:2], alpha),
                             mix(ov_rgb[1:0], bg_rgb[1:0], alpha)};
            else
                blend_rgb = bg_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= 6'd0;
            hsync_out <= SYNC_IDLE;
            vsync_out <= SYNC_IDLE;
            vs_hist   <= SYNC_IDLE;
        end else begin
            rgb_out   <= blend_rgb;
            hsync_out <= hsync;
            vsync_out <= vsync;
            vs_hist   <= vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HIDDEN;
            alpha     <= 3'd0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else if (frame_tick) begin
            case (state)
                HIDDEN: begin
                    if (show_req) begin
                        state     <= FADE_IN;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                FADE_IN: begin
                    // A reversal restarts the frame count but never steps alpha.
                    if (!show_req) begin
                        state     <= FADE_OUT;
                        frame_cnt <= '0;
                    end else if (frame_cnt == CNT_LAST) begin
                        alpha     <= alpha + 3'd1;
                        frame_cnt <= '0;
                        if (alpha == 3'd3) begin
                            state <= SHOWN;
                            busy  <= 1'b0;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end
                SHOWN: begin
                    if (!show_req) begin
                        state     <= FADE_OUT;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (show_req) begin
                        state     <= FADE_IN;
                        frame_cnt <= '0;
                    end else if (frame_cnt == CNT_LAST) begin
                        alpha     <= alpha - 3'd1;
                        frame_cnt <= '0;
                        if (alpha == 3'd1) begin
                            state <= HIDDEN;
                            busy  <= 1'b0;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= HIDDEN;
                    alpha     <= 3'd0;
                    frame_cnt <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
